// File: rtl/rtc_access_sched.sv
// Purpose: sequences DS1302-style transactions, arbitrating a periodic time poll against user time writes.
// Latency: a burst starts one cycle after arbitration; each step is ISSUE + WAIT_BUSY + WAIT_DONE (>= 3 cycles).
// Backpressure: the engine paces each step via eng_ready; wr_req is held until wr_ack; poll ticks merge while pending.
//
// Ports: clk/rst (sync, active-high); wr_req/wr_sec/wr_min/wr_hour -> wr_ack (write requester);
//        rd_sec/rd_min/rd_hour + time_valid (polled time); busy, err (sticky timeout);
//        eng_addr/eng_wdata/eng_send -> engine, eng_ready/eng_rdata <- engine.
// Optional: define RTC_WP_HANDLING_EN to wrap write bursts in write-protect clear/set steps.
module rtc_access_sched #(
    parameter int POLL_PERIOD = 25000000,
    parameter int TIMEOUT_CYC = 8192
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_req,
    input  logic [7:0] wr_sec,
    input  logic [7:0] wr_min,
    input  logic [7:0] wr_hour,
    output logic       wr_ack,
    output logic [7:0] rd_sec,
    output logic [7:0] rd_min,
    output logic [7:0] rd_hour,
    output logic       time_valid,
    output logic       busy,
    output logic       err,
    output logic [7:0] eng_addr,
    output logic [7:0] eng_wdata,
    output logic       eng_send,
    input  logic       eng_ready,
    input  logic [7:0] eng_rdata
);

    localparam int PCW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int TCW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [PCW-1:0] POLL_MAX = PCW'(POLL_PERIOD - 1);
    localparam logic [TCW-1:0] TO_MAX   = TCW'(TIMEOUT_CYC - 1);
    localparam logic [2:0]     RD_LAST  = 3'd2;
`ifdef RTC_WP_HANDLING_EN
    localparam logic [2:0]     WR_LAST  = 3'd4;
`else
    localparam logic [2:0]     WR_LAST  = 3'd2;
`endif

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t         state;
    logic [PCW-1:0] poll_cnt;
    logic           poll_pend;
    logic           poll_wrap;
    logic [TCW-1:0] to_cnt;
    logic           is_wr;
    logic [2:0]     step;
    logic [7:0]     lat_sec, lat_min, lat_hour;
    logic [7:0]     sh_sec, sh_min;

    assign poll_wrap = (poll_cnt == POLL_MAX);

    // {command byte, data byte} for a given burst kind and step index.
    function automatic logic [15:0] step_cmd(input logic wr, input logic [2:0] st,
                                             input logic [7:0] s, input logic [7:0] m,
                                             input logic [7:0] h);
        logic [2:0] t;
        step_cmd = 16'h0000;
        t = st;
        if (!wr) begin
            case (st)
                3'd0:    step_cmd = 16'h8100;
                3'd1:    step_cmd = 16'h8300;
                default: step_cmd = 16'h8500;
            endcase
        end else begin
`ifdef RTC_WP_HANDLING_EN
            t = st - 3'd1;
`endif
            case (t)
                3'd0:    step_cmd = {8'h80, s & 8'h7F};  // CH bit cleared so the oscillator runs
                3'd1:    step_cmd = {8'h82, m};
                default: step_cmd = {8'h84, h};
            endcase
`ifdef RTC_WP_HANDLING_EN
            if (st == 3'd0) step_cmd = 16'h8E00;
            if (st == 3'd4) step_cmd = 16'h8E80;
`endif
        end
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            poll_cnt   <= '0;
            poll_pend  <= 1'b0;
            to_cnt     <= '0;
            is_wr      <= 1'b0;
            step       <= 3'd0;
            lat_sec    <= 8'h00;
            lat_min    <= 8'h00;
            lat_hour   <= 8'h00;
            sh_sec     <= 8'h00;
            sh_min     <= 8'h00;
            wr_ack     <= 1'b0;
            rd_sec     <= 8'h00;
            rd_min     <= 8'h00;
            rd_hour    <= 8'h00;
            time_valid <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
            eng_addr   <= 8'h00;
            eng_wdata  <= 8'h00;
            eng_send   <= 1'b0;
        end else begin
            wr_ack     <= 1'b0;
            time_valid <= 1'b0;
            eng_send   <= 1'b0;

            poll_cnt <= poll_wrap ? '0 : poll_cnt + 1'b1;
            if (poll_wrap) poll_pend <= 1'b1;

            case (state)
                IDLE: begin
                    if (eng_ready && (wr_req || poll_pend)) begin
                        is_wr    <= wr_req;
                        step     <= 3'd0;
                        state    <= ISSUE;
                        busy     <= 1'b1;
                        eng_send <= 1'b1;
                        {eng_addr, eng_wdata} <= step_cmd(wr_req, 3'd0, wr_sec, wr_min, wr_hour);
                        if (wr_req) begin
                            lat_sec  <= wr_sec;
                            lat_min  <= wr_min;
                            lat_hour <= wr_hour;
                        end else begin
                            // A tick landing on the start edge is absorbed by this burst.
                            poll_pend <= poll_wrap;
                        end
                    end
                end
                ISSUE: begin
                    state  <= WAIT_BUSY;
                    to_cnt <= '0;
                end
                WAIT_BUSY: begin
                    if (!eng_ready) begin
                        state  <= WAIT_DONE;
                        to_cnt <= '0;
                    end else if (to_cnt == TO_MAX) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (eng_ready) begin
                        if (!is_wr && step == 3'd0) sh_sec <= eng_rdata;
                        if (!is_wr && step == 3'd1) sh_min <= eng_rdata;
                        if (step == (is_wr ? WR_LAST : RD_LAST)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            if (is_wr) begin
                                wr_ack <= 1'b1;
                            end else begin
                                // Hours come straight from the bus so all three update together.
                                rd_sec     <= sh_sec & 8'h7F;
                                rd_min     <= sh_min;
                                rd_hour    <= eng_rdata;
                                time_valid <= 1'b1;
                            end
                        end else begin
                            step     <= step + 3'd1;
                            state    <= ISSUE;
                            eng_send <= 1'b1;
                            {eng_addr, eng_wdata} <= step_cmd(is_wr, step + 3'd1, lat_sec, lat_min, lat_hour);
                        end
                    end else if (to_cnt == TO_MAX) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_access_sched.sv
module tb_rtc_access_sched;

    localparam int PP = 1000;
    localparam int TO = 4096;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_req = 1'b0;
    logic [7:0] wr_sec = 8'h00, wr_min = 8'h00, wr_hour = 8'h00;
    logic       wr_ack, time_valid, busy, err, eng_send;
    logic [7:0] rd_sec, rd_min, rd_hour, eng_addr, eng_wdata;
    logic       eng_ready = 1'b1;
    logic [7:0] eng_rdata = 8'h00;

    int total = 0;
    int bad   = 0;

    logic [15:0] log_q[$];
    logic [15:0] exp_q[$];
    logic [7:0]  ord_q[$];
    int tv_cnt  = 0;
    int ack_cnt = 0;

    bit hang = 1'b0;
    bit force_low = 1'b0;
    int stall_at = -1;
    int stall_len = 0;
    logic [7:0] v_sec = 8'h00, v_min = 8'h00, v_hour = 8'h00;

    rtc_access_sched #(.POLL_PERIOD(PP), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .wr_req(wr_req),
        .wr_sec(wr_sec), .wr_min(wr_min), .wr_hour(wr_hour), .wr_ack(wr_ack),
        .rd_sec(rd_sec), .rd_min(rd_min), .rd_hour(rd_hour), .time_valid(time_valid),
        .busy(busy), .err(err),
        .eng_addr(eng_addr), .eng_wdata(eng_wdata), .eng_send(eng_send),
        .eng_ready(eng_ready), .eng_rdata(eng_rdata)
    );

    always #5 clk = ~clk;

    // Simulated RTC register contents seen by the engine.
    function automatic logic [7:0] rtc_val(input logic [7:0] a);
        case (a)
            8'h81:   return v_sec;
            8'h83:   return v_min;
            8'h85:   return v_hour;
            default: return 8'hEE;
        endcase
    endfunction

    // Engine model: logs every strobe, checks strobe spacing and address hold.
    initial begin
        int ph, cnt, gap;
        logic [7:0] cur_addr;
        ph = 0; cnt = 0; gap = 100; cur_addr = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                ph = 0; gap = 100; eng_ready = 1'b1;
                continue;
            end
            if (eng_send) begin
                total++;
                if (gap < 2) begin
                    bad++;
                    $display("FAIL send_gap: %0d idle cycles before strobe, need >= 2", gap);
                end
                gap = 0;
                log_q.push_back({eng_addr, eng_wdata});
                cur_addr = eng_addr;
                if (!hang) begin
                    ph = 1;
                    cnt = $urandom_range(0, 2);
                end
            end else begin
                gap++;
            end
            case (ph)
                1: begin
                    if (cnt == 0) begin
                        eng_ready = 1'b0;
                        cnt = (log_q.size() == stall_at) ? stall_len : $urandom_range(1, 4);
                        ph = 2;
                    end else cnt--;
                end
                2: begin
                    if (cnt == 0) begin
                        total++;
                        if (eng_addr !== cur_addr) begin
                            bad++;
                            $display("FAIL addr_hold: eng_addr=%h, issued %h", eng_addr, cur_addr);
                        end
                        eng_rdata = rtc_val(cur_addr);
                        eng_ready = 1'b1;
                        ph = 0;
                    end else cnt--;
                end
                default: eng_ready = force_low ? 1'b0 : 1'b1;
            endcase
        end
    end

    // Pulse monitor.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (time_valid) begin tv_cnt++; ord_q.push_back(8'h52); end
            if (wr_ack)     begin ack_cnt++; ord_q.push_back(8'h57); end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic wait_tv(input int budget, output bit ok);
        int start = tv_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (tv_cnt != start) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_ack(input int budget, output bit ok);
        int start = ack_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (ack_cnt != start) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_busy(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (busy === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic push_read();
        exp_q.push_back(16'h8100);
        exp_q.push_back(16'h8300);
        exp_q.push_back(16'h8500);
    endtask

    task automatic push_write(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h);
`ifdef RTC_WP_HANDLING_EN
        exp_q.push_back(16'h8E00);
`endif
        exp_q.push_back({8'h80, 1'b0, s[6:0]});
        exp_q.push_back({8'h82, m});
        exp_q.push_back({8'h84, h});
`ifdef RTC_WP_HANDLING_EN
        exp_q.push_back(16'h8E80);
`endif
    endtask

    function automatic bit log_ok();
        if (log_q.size() != exp_q.size()) return 1'b0;
        foreach (exp_q[i]) if (log_q[i] !== exp_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_obs();
        log_q.delete(); exp_q.delete(); ord_q.delete();
        tv_cnt = 0; ack_cnt = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_req = 1'b0;
        repeat (3) tick();
        total++;
        if ({rd_sec, rd_min, rd_hour} !== 24'h0) begin
            bad++; $display("FAIL reset_rd: got %h, want 000000", {rd_sec, rd_min, rd_hour});
        end
        total++;
        if ({wr_ack, time_valid, busy, err, eng_send} !== 5'b0) begin
            bad++; $display("FAIL reset_flags: got %b, want 00000", {wr_ack, time_valid, busy, err, eng_send});
        end
        total++;
        if ({eng_addr, eng_wdata} !== 16'h0) begin
            bad++; $display("FAIL reset_eng: got %h, want 0000", {eng_addr, eng_wdata});
        end
        clear_obs();
        rst = 1'b0;
    endtask

    task automatic test_poll_fixed();
        int cyc = 0;
        v_sec = 8'h85; v_min = 8'h59; v_hour = 8'h23;
        push_read();
        while (tv_cnt == 0 && cyc < PP + 100) begin tick(); cyc++; end
        total++;
        if (cyc < 1008 || cyc > 1030) begin
            bad++; $display("FAIL poll_first_time: time_valid after %0d cycles, want 1008..1030", cyc);
        end
        total++;
        if (!log_ok()) begin
            bad++; $display("FAIL poll_log: %0d strobes logged, want 81/83/85 (3)", log_q.size());
        end
        total++;
        if ({rd_sec, rd_min, rd_hour} !== 24'h055923) begin
            bad++; $display("FAIL poll_rd: got %h, want 055923", {rd_sec, rd_min, rd_hour});
        end
        repeat (3) tick();
        total++;
        if (tv_cnt !== 1 || busy !== 1'b0) begin
            bad++; $display("FAIL poll_pulse: tv_cnt=%0d busy=%b, want 1 and 0", tv_cnt, busy);
        end
    endtask

    task automatic test_poll_random();
        bit ok;
        for (int n = 0; n < 3; n++) begin
            clear_obs();
            v_sec = 8'($urandom); v_min = 8'($urandom); v_hour = 8'($urandom);
            push_read();
            wait_tv(PP + 100, ok);
            total++;
            if (!ok || !log_ok()) begin
                bad++; $display("FAIL poll_rand_log[%0d]: ok=%b strobes=%0d, want 1 and 3", n, ok, log_q.size());
            end
            total++;
            if ({rd_sec, rd_min, rd_hour} !== {v_sec & 8'h7F, v_min, v_hour}) begin
                bad++; $display("FAIL poll_rand_rd[%0d]: got %h, want %h", n,
                                {rd_sec, rd_min, rd_hour}, {v_sec & 8'h7F, v_min, v_hour});
            end
        end
    endtask

    task automatic test_write();
        bit ok;
        for (int n = 0; n < 3; n++) begin
            clear_obs();
            if (n == 0) begin wr_sec = 8'h30; wr_min = 8'h15; wr_hour = 8'h12; end
            else begin wr_sec = 8'($urandom); wr_min = 8'($urandom); wr_hour = 8'($urandom); end
            push_write(wr_sec, wr_min, wr_hour);
            wr_req = 1'b1;
            wait_ack(200, ok);
            wr_req = 1'b0;
            wr_sec = 8'h00; wr_min = 8'h00; wr_hour = 8'h00;
            repeat (4) tick();
            total++;
            if (!ok || !log_ok()) begin
                bad++; $display("FAIL write_log[%0d]: ok=%b strobes=%0d, want 1 and %0d", n, ok, log_q.size(), exp_q.size());
            end
            total++;
            if (ack_cnt !== 1 || tv_cnt !== 0) begin
                bad++; $display("FAIL write_pulse[%0d]: acks=%0d tvs=%0d, want 1 and 0", n, ack_cnt, tv_cnt);
            end
        end
    endtask

    task automatic test_wr_drop();
        bit ok, ok2;
        clear_obs();
        wr_sec = 8'h45; wr_min = 8'h07; wr_hour = 8'h09;
        push_write(8'h45, 8'h07, 8'h09);
        wr_req = 1'b1;
        wait_busy(20, ok);
        wr_req = 1'b0;
        wr_sec = 8'hFF; wr_min = 8'hFF; wr_hour = 8'hFF;
        wait_ack(200, ok2);
        repeat (4) tick();
        total++;
        if (!ok || !ok2 || ack_cnt !== 1) begin
            bad++; $display("FAIL wr_drop_ack: busy_seen=%b ack_seen=%b acks=%0d, want 1 1 1", ok, ok2, ack_cnt);
        end
        total++;
        if (!log_ok()) begin
            bad++; $display("FAIL wr_drop_log: %0d strobes, want %0d with latched data", log_q.size(), exp_q.size());
        end
    endtask

    task automatic test_collision();
        bit ok, ok2;
        wait_tv(PP + 100, ok);
        clear_obs();
        force_low = 1'b1;
        repeat (PP + 50) tick();
        wr_sec = 8'h11; wr_min = 8'h22; wr_hour = 8'h05;
        wr_req = 1'b1;
        push_write(8'h11, 8'h22, 8'h05);
        push_read();
        tick();
        force_low = 1'b0;
        wait_ack(200, ok2);
        wr_req = 1'b0;
        wait_tv(200, ok2);
        repeat (4) tick();
        total++;
        if (!ok || ord_q.size() != 2 || ord_q[0] !== 8'h57 || ord_q[1] !== 8'h52) begin
            bad++; $display("FAIL collide_order: %0d pulses, want wr_ack then time_valid", ord_q.size());
        end
        total++;
        if (!log_ok()) begin
            bad++; $display("FAIL collide_log: %0d strobes, want %0d (write then read)", log_q.size(), exp_q.size());
        end
    endtask

    task automatic test_merge();
        bit ok, ok2;
        wait_tv(PP + 100, ok);
        clear_obs();
        stall_at = 2; stall_len = 3050;
        wr_sec = 8'h59; wr_min = 8'h59; wr_hour = 8'h23;
        push_write(8'h59, 8'h59, 8'h23);
        push_read();
        wr_req = 1'b1;
        wait_ack(3400, ok2);
        wr_req = 1'b0;
        stall_at = -1;
        repeat (300) tick();
        total++;
        if (!ok || !ok2 || tv_cnt !== 1) begin
            bad++; $display("FAIL merge_count: sync=%b ack=%b read bursts=%0d, want 1 1 1", ok, ok2, tv_cnt);
        end
        total++;
        if (!log_ok()) begin
            bad++; $display("FAIL merge_log: %0d strobes, want %0d", log_q.size(), exp_q.size());
        end
    endtask

    task automatic test_timeout();
        bit ok, ok2, seen;
        logic [23:0] rd_exp;
        wait_tv(PP + 100, ok);
        rd_exp = {v_sec & 8'h7F, v_min, v_hour};
        clear_obs();
        hang = 1'b1;
        wr_sec = 8'h01; wr_min = 8'h02; wr_hour = 8'h03;
        wr_req = 1'b1;
        wait_busy(20, ok2);
        repeat (TO - 4) tick();
        total++;
        if (!ok || !ok2 || err !== 1'b0) begin
            bad++; $display("FAIL timeout_early: err=%b before limit, want 0", err);
        end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (err === 1'b1) begin seen = 1'b1; break; end
        end
        hang = 1'b0;
        total++;
        if (!seen || busy !== 1'b0) begin
            bad++; $display("FAIL timeout_err: err_seen=%b busy=%b, want 1 and 0", seen, busy);
        end
        total++;
        if ({rd_sec, rd_min, rd_hour} !== rd_exp || tv_cnt !== 0 || ack_cnt !== 0) begin
            bad++; $display("FAIL timeout_quiet: rd=%h tvs=%0d acks=%0d, want %h 0 0",
                            {rd_sec, rd_min, rd_hour}, tv_cnt, ack_cnt, rd_exp);
        end
        wait_ack(200, ok);
        wr_req = 1'b0;
        total++;
        if (!ok || err !== 1'b1) begin
            bad++; $display("FAIL timeout_retry: ack=%b err=%b, want 1 and sticky 1", ok, err);
        end
    endtask

    task automatic test_reset_mid();
        bit ok, ok2;
        wait_tv(200, ok);
        clear_obs();
        stall_at = 2; stall_len = 200;
        wr_sec = 8'h12; wr_min = 8'h34; wr_hour = 8'h10;
        wr_req = 1'b1;
        ok2 = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (log_q.size() == 2 && eng_ready === 1'b0) begin ok2 = 1'b1; break; end
        end
        repeat (3) tick();
        rst = 1'b1; wr_req = 1'b0;
        tick();
        total++;
        if (!ok || !ok2 || {wr_ack, time_valid, busy, err, eng_send} !== 5'b0 ||
            {eng_addr, eng_wdata, rd_sec, rd_min, rd_hour} !== 40'h0) begin
            bad++; $display("FAIL reset_mid: flags=%b eng=%h rd=%h, want all zero",
                            {wr_ack, time_valid, busy, err, eng_send}, {eng_addr, eng_wdata},
                            {rd_sec, rd_min, rd_hour});
        end
        rst = 1'b0;
        stall_at = -1;
        repeat (20) tick();
        total++;
        if (ack_cnt !== 0 || tv_cnt !== 0 || log_q.size() != 2 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_mid_after: acks=%0d tvs=%0d strobes=%0d busy=%b, want 0 0 2 0",
                            ack_cnt, tv_cnt, log_q.size(), busy);
        end
    endtask

    initial begin
        test_reset();
        test_poll_fixed();
        test_poll_random();
        test_write();
        test_wr_drop();
        test_collision();
        test_merge();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
